// File: rtl/sd_sector_model.sv
// Behavioural SD sector controller: serves paced sector reads and writes from an
// internal byte array through the rd/wr/byte-strobe handshake of the SPI controller.
module sd_sector_model #(
    parameter int    SECTOR_BYTES = 512,
    parameter int    NUM_SECTORS  = 8,
    parameter int    INIT_CYCLES  = 16,
    parameter int    BYTE_GAP     = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] address,
    output logic [7:0]  dout,
    output logic        byte_available,
    input  logic [7:0]  din,
    output logic        ready_for_next_byte,
    output logic        ready,
    output logic        error,
    output logic [2:0]  status
);

    localparam int IDX_W = $clog2(SECTOR_BYTES);
    localparam int SEC_W = (NUM_SECTORS > 1) ? $clog2(NUM_SECTORS) : 1;
    localparam int GAP_W = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int AW    = SEC_W + IDX_W;
    localparam int DEPTH = SECTOR_BYTES * NUM_SECTORS;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e           state, state_n;
    logic [CNT_W-1:0] init_cnt, init_cnt_n;
    logic [GAP_W-1:0] gap, gap_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [SEC_W-1:0] sector, sector_n;
    logic             error_n;
    logic             strobe;
    logic             addr_ok;
    logic [7:0]       mem [DEPTH];

    // Time-zero contents only; reset never touches the array.
    initial begin
        for (int unsigned s = 0; s < NUM_SECTORS; s++) begin
            for (int unsigned i = 0; i < SECTOR_BYTES; i++) begin
                mem[AW'(s * SECTOR_BYTES + i)] = 8'(i + s);
            end
        end
    end

    assign strobe  = (gap == GAP_W'(BYTE_GAP));
    assign addr_ok = (address[IDX_W-1:0] == '0) &&
                     ((address >> IDX_W) < 32'(NUM_SECTORS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_INIT;
            init_cnt <= '0;
            gap      <= '0;
            idx      <= '0;
            sector   <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
            gap      <= gap_n;
            idx      <= idx_n;
            sector   <= sector_n;
            error    <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        gap_n      = gap;
        idx_n      = idx;
        sector_n   = sector;
        error_n    = error;
        case (state)
            S_INIT: begin
                if (init_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    init_cnt_n = init_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (rd || wr) begin
                    gap_n    = '0;
                    idx_n    = '0;
                    sector_n = address[IDX_W +: SEC_W];
                    if (addr_ok) begin
                        error_n = 1'b0;
                        state_n = rd ? S_READ : S_WRITE;
                    end else begin
                        error_n = 1'b1;
                    end
                end
            end
            S_READ, S_WRITE: begin
                if (strobe) begin
                    gap_n = '0;
                    idx_n = idx + 1'b1;
                    if (idx == '1) begin
                        state_n = S_DONE;
                    end
                end else begin
                    gap_n = gap + 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

    assign ready               = (state == S_IDLE);
    assign status              = state;
    assign byte_available      = (state == S_READ) && strobe;
    assign ready_for_next_byte = (state == S_WRITE) && strobe;

    // dout is fetched one edge early from the next-state values so it is
    // already valid during the strobe cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (state_n == S_READ && gap_n == GAP_W'(BYTE_GAP)) begin
            dout <= mem[{sector_n, idx_n}];
        end else if (state_n == S_DONE) begin
            dout <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ready_for_next_byte) begin
            mem[{sector, idx}] <= din;
        end
    end

endmodule

// File: tb/tb_sd_sector_model.sv
// Bench for sd_sector_model: cycle-timeline reference model plus directed and random stimulus.
module tb_sd_sector_model;

    localparam int SB   = 512;
    localparam int NS   = 8;
    localparam int IC   = 16;
    localparam int G    = 1;
    localparam int XFER = SB * (G + 1);

    logic        clk = 1'b0;
    logic        reset, rd, wr;
    logic [31:0] address;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        byte_available, ready_for_next_byte, ready, error;
    logic [2:0]  status;

    logic        reset0, rd0, wr0;
    logic [31:0] address0;
    logic [7:0]  din0;
    logic [7:0]  dout0;
    logic        byte_available0, ready_for_next_byte0, ready0, error0;
    logic [2:0]  status0;

    sd_sector_model #(.SECTOR_BYTES(SB), .NUM_SECTORS(NS), .INIT_CYCLES(IC),
                      .BYTE_GAP(G), .INIT_FILE("")) u_dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .address(address),
        .dout(dout), .byte_available(byte_available), .din(din),
        .ready_for_next_byte(ready_for_next_byte), .ready(ready),
        .error(error), .status(status)
    );

    sd_sector_model #(.SECTOR_BYTES(SB), .NUM_SECTORS(NS), .INIT_CYCLES(4),
                      .BYTE_GAP(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(reset0), .rd(rd0), .wr(wr0), .address(address0),
        .dout(dout0), .byte_available(byte_available0), .din(din0),
        .ready_for_next_byte(ready_for_next_byte0), .ready(ready0),
        .error(error0), .status(status0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 INIT, 1 IDLE, 2 transfer; m_t = cycles since acceptance.
    logic [7:0] mem_m [SB*NS];
    int   m_mode, m_init_cnt, m_t, m_sector;
    bit   m_is_rd, m_err;
    bit   m_valid = 1'b0;
    bit   din_mode;

    initial begin
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < SB; i++)
                mem_m[s*SB + i] = 8'((i + s) % 256);
    end

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= 0; m_init_cnt <= 0; m_err <= 1'b0; m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_mode)
                0: begin
                    m_init_cnt <= m_init_cnt + 1;
                    if (m_init_cnt + 1 == IC) m_mode <= 1;
                end
                1: if (rd || wr) begin
                    if ((address % SB) != 0 || (address / SB) >= NS) m_err <= 1'b1;
                    else begin
                        m_err <= 1'b0; m_mode <= 2; m_is_rd <= rd; m_t <= 0;
                        m_sector <= int'(address / SB);
                    end
                end
                default: begin
                    if (m_t == XFER) m_mode <= 1;
                    else begin
                        if (!m_is_rd && (m_t % (G + 1)) == G)
                            mem_m[m_sector*SB + m_t/(G + 1)] <= din;
                        m_t <= m_t + 1;
                    end
                end
            endcase
        end
    end

    // Write data is a function of the byte index in directed tests, random otherwise.
    always @(posedge clk) begin
        #1;
        if (din_mode) din = 8'hA5 ^ 8'(m_t / (G + 1));
        else          din = 8'($urandom);
    end

    logic [7:0] rd_log [SB];
    int rd_cnt, n_ba, n_rfn;

    task automatic clear_log();
        rd_cnt = 0; n_ba = 0; n_rfn = 0;
    endtask

    always @(negedge clk) begin
        if (byte_available) begin
            if (rd_cnt < SB) rd_log[rd_cnt] = dout;
            rd_cnt++;
            n_ba++;
        end
        if (ready_for_next_byte) n_rfn++;
        if (m_valid) begin
            int e_status;
            logic e_ba, e_rfn;
            e_ba = 1'b0; e_rfn = 1'b0;
            if (m_mode == 0)      e_status = 0;
            else if (m_mode == 1) e_status = 1;
            else if (m_t >= XFER) e_status = 4;
            else begin
                e_status = m_is_rd ? 2 : 3;
                if ((m_t % (G + 1)) == G) begin
                    e_ba = m_is_rd; e_rfn = !m_is_rd;
                end
            end
            chk("status", status, e_status);
            chk("ready", ready, m_mode == 1);
            chk("error", error, m_err);
            chk("byte_available", byte_available, e_ba);
            chk("ready_for_next_byte", ready_for_next_byte, e_rfn);
            if (e_ba) chk("dout", dout, mem_m[m_sector*SB + m_t/(G + 1)]);
            if (e_status == 0 || e_status == 4) chk("dout_zero", dout, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int budget, output int n);
        n = 0;
        while (!ready && n < budget) begin
            tick(1);
            n++;
        end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL %s timeout ready=0 required=1 after %0d cycles", name, n);
        end
    endtask

    task automatic read_sector(input string name, input logic [31:0] a);
        int n;
        clear_log();
        address = a; rd = 1'b1; tick(1); rd = 1'b0;
        wait_ready(name, 2 * XFER, n);
        chk(name, n, XFER + 1);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, NS - 1)) * SB;
        else if (r == 7) return 32'($urandom_range(NS, NS + 20)) * SB;
        else if (r == 8) return 32'($urandom_range(0, NS*SB - 1)) | 32'h1;
        else             return 32'h8000_0000 | (32'($urandom) & 32'hFFFF_FE00);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, run, maxrun, c_ba, c_rfn;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; address = '0; din_mode = 1'b0;
        reset0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; address0 = '0; din0 = '0;
        tick(3);
        chk("rst_status", status, 0);
        chk("rst_ready", ready, 0);
        chk("rst_dout", dout, 0);
        chk("rst_strobes", {byte_available, ready_for_next_byte, error}, 0);
        reset = 1'b0; reset0 = 1'b0;
        n = 0;
        while (!ready && n < 100) begin tick(1); n++; end
        chk("init_cycles", n, IC);
        chk("idle_status", status, 1);

        // Read sector 1
        clear_log();
        address = 32'h200; rd = 1'b1; tick(1); rd = 1'b0;
        chk("rd_ready_fall", ready, 0);
        wait_ready("rd_s1_wait", 2 * XFER, n);
        chk("rd_s1_len", n, XFER + 1);
        chk("rd_s1_count", rd_cnt, SB);
        chk("rd_s1_b0", rd_log[0], 8'h01);
        chk("rd_s1_b254", rd_log[254], 8'hFF);
        chk("rd_s1_b255", rd_log[255], 8'h00);
        chk("rd_s1_rfn", n_rfn, 0);

        // Write sector 2 then read back; sector 3 untouched
        clear_log();
        din_mode = 1'b1;
        address = 32'h400; wr = 1'b1; tick(1); wr = 1'b0;
        wait_ready("wr_s2_wait", 2 * XFER, n);
        din_mode = 1'b0;
        chk("wr_s2_len", n, XFER + 1);
        chk("wr_s2_count", n_rfn, SB);
        chk("wr_s2_ba", n_ba, 0);
        read_sector("rd_s2_len", 32'h400);
        bad = 0;
        for (int k = 0; k < SB; k++) if (rd_log[k] !== (8'hA5 ^ 8'(k))) bad++;
        chk("wr_s2_readback_bad", bad, 0);
        chk("wr_s2_b3", rd_log[3], 8'hA6);
        read_sector("rd_s3_len", 32'h600);
        chk("rd_s3_b0", rd_log[0], 8'h03);
        chk("rd_s3_b253", rd_log[253], 8'h00);

        // Rejected commands
        clear_log();
        address = 32'h201; rd = 1'b1; tick(1); rd = 1'b0;
        chk("err_misalign", error, 1);
        chk("err_misalign_ready", ready, 1);
        address = 32'h1000; wr = 1'b1; tick(1); wr = 1'b0;
        chk("err_range", error, 1);
        tick(3);
        chk("err_sticky", error, 1);
        chk("err_no_strobe", n_ba + n_rfn, 0);
        clear_log();
        address = 32'h0; rd = 1'b1; tick(1); rd = 1'b0;
        chk("err_clear", error, 0);
        wait_ready("rd_s0_wait", 2 * XFER, n);
        chk("rd_s0_b5", rd_log[5], 8'h05);

        // Reset after 100 written bytes of sector 3
        clear_log();
        din_mode = 1'b1;
        address = 32'h600; wr = 1'b1; tick(1); wr = 1'b0;
        n = 0;
        while (n_rfn < 100 && n < 1000) begin @(negedge clk); #1; n++; end
        chk("rst_mid_reach", n_rfn, 100);
        @(posedge clk); #1;
        reset = 1'b1; tick(1); reset = 1'b0;
        din_mode = 1'b0;
        chk("rst_mid_status", status, 0);
        chk("rst_mid_ready", ready, 0);
        chk("rst_mid_outs", {byte_available, ready_for_next_byte, error}, 0);
        chk("rst_mid_dout", dout, 0);
        wait_ready("rst_mid_init_wait", 100, n);
        chk("rst_mid_init", n, IC);
        read_sector("rd_s3b_len", 32'h600);
        chk("rst_mid_b99", rd_log[99], 8'hA5 ^ 8'd99);
        chk("rst_mid_b100", rd_log[100], 8'd103);
        chk("rst_mid_b511", rd_log[511], 8'h02);
        bad = 0;
        for (int k = 0; k < 100; k++) if (rd_log[k] !== (8'hA5 ^ 8'(k))) bad++;
        for (int k = 100; k < SB; k++) if (rd_log[k] !== 8'((k + 3) % 256)) bad++;
        chk("rst_mid_bad", bad, 0);

        // Random traffic, including stray requests and rare resets
        for (int c = 0; c < 12000; c++) begin
            rd = ($urandom_range(0, 15) == 0);
            wr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) address = rand_addr();
            reset = ($urandom_range(0, 2999) == 0);
            tick(1);
        end
        rd = 1'b0; wr = 1'b0; reset = 1'b0;

        // BYTE_GAP = 0 instance: rd and wr together, read wins
        chk("g0_ready", ready0, 1);
        address0 = 32'h200; rd0 = 1'b1; wr0 = 1'b1; tick(1); rd0 = 1'b0; wr0 = 1'b0;
        chk("g0_first_ba", byte_available0, 1);
        chk("g0_status", status0, 2);
        run = 0; maxrun = 0; c_ba = 0; c_rfn = 0; bad = 0;
        for (int k = 0; k < SB + 50; k++) begin
            @(negedge clk);
            if (byte_available0) begin
                if (dout0 !== 8'(c_ba + 1)) bad++;
                c_ba++; run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
            if (ready_for_next_byte0) c_rfn++;
        end
        chk("g0_count", c_ba, SB);
        chk("g0_consecutive", maxrun, SB);
        chk("g0_rfn", c_rfn, 0);
        chk("g0_data_bad", bad, 0);
        chk("g0_ready_back", ready0, 1);
        chk("g0_error", error0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
